// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/wb_watchdog.sv
// Transaction watchdog: counts busy cycles and flags expiry one count short of TIMEOUT.
module wb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
      logic [CW-1:0] cnt;

      // Saturates at LIMIT so a held expiry never wraps back to a quiet count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expire = en && (cnt == LIMIT);
    end else begin : g_no_wd
      logic unused_wd;
      assign unused_wd = clk ^ rst ^ clr ^ en;
      assign expire    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC, with a
// watchdog that aborts a hung slave transaction by returning ERR to the owner.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_data,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  output logic            o_m0_stall,
  output logic [DW-1:0]   o_m0_data,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_data,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic            o_m1_stall,
  output logic [DW-1:0]   o_m1_data,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_data,
  output logic [DW/8-1:0] o_s_sel,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  input  logic            i_s_stall,
  input  logic [DW-1:0]   i_s_data,
  output logic [1:0]      o_grant,
  output logic            o_timeout
);

  arb_state_t state, state_nxt;
  mst_idx_t   last, last_nxt;
  logic       abort_first, abort_first_nxt;
  logic       grant_entry;
  logic       wd_en;
  logic       wd_expire;
  logic       owner_cyc;
  logic       s_resp;

  assign owner_cyc = last ? i_m1_cyc : i_m0_cyc;
  assign s_resp    = i_s_ack || i_s_err;
  assign wd_en     = (state == GRANT0) || (state == GRANT1);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (i_clk),
    .rst    (i_reset),
    .clr    (grant_entry || s_resp),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      abort_first <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      abort_first <= abort_first_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    last_nxt        = last;
    abort_first_nxt = 1'b0;
    grant_entry     = 1'b0;
    o_s_cyc         = 1'b0;
    o_s_stb         = 1'b0;
    o_s_we          = 1'b0;
    o_s_addr        = '0;
    o_s_data        = '0;
    o_s_sel         = '0;
    o_m0_ack        = 1'b0;
    o_m0_err        = 1'b0;
    o_m0_stall      = 1'b0;
    o_m0_data       = '0;
    o_m1_ack        = 1'b0;
    o_m1_err        = 1'b0;
    o_m1_stall      = 1'b0;
    o_m1_data       = '0;
    o_grant         = 2'b00;
    o_timeout       = 1'b0;

    case (state)
      IDLE: begin
        o_m0_stall = i_m0_cyc;
        o_m1_stall = i_m1_cyc;
        if (i_m0_cyc && i_m1_cyc) begin
          state_nxt = last ? GRANT0 : GRANT1;
        end else if (i_m0_cyc) begin
          state_nxt = GRANT0;
        end else if (i_m1_cyc) begin
          state_nxt = GRANT1;
        end
      end

      GRANT0: begin
        o_grant    = 2'b01;
        o_s_cyc    = i_m0_cyc;
        o_s_stb    = i_m0_stb;
        o_s_we     = i_m0_we;
        o_s_addr   = i_m0_addr;
        o_s_data   = i_m0_data;
        o_s_sel    = i_m0_sel;
        o_m0_ack   = i_s_ack;
        o_m0_err   = i_s_err;
        o_m0_stall = i_s_stall;
        o_m0_data  = i_s_data;
        o_m1_stall = i_m1_cyc;
        // Release takes priority over expiry; a slave response beats the watchdog.
        if (!i_m0_cyc) begin
          state_nxt = i_m1_cyc ? GRANT1 : IDLE;
        end else if (wd_expire && !s_resp) begin
          state_nxt       = ABORT;
          abort_first_nxt = 1'b1;
        end
      end

      GRANT1: begin
        o_grant    = 2'b10;
        o_s_cyc    = i_m1_cyc;
        o_s_stb    = i_m1_stb;
        o_s_we     = i_m1_we;
        o_s_addr   = i_m1_addr;
        o_s_data   = i_m1_data;
        o_s_sel    = i_m1_sel;
        o_m1_ack   = i_s_ack;
        o_m1_err   = i_s_err;
        o_m1_stall = i_s_stall;
        o_m1_data  = i_s_data;
        o_m0_stall = i_m0_cyc;
        if (!i_m1_cyc) begin
          state_nxt = i_m0_cyc ? GRANT0 : IDLE;
        end else if (wd_expire && !s_resp) begin
          state_nxt       = ABORT;
          abort_first_nxt = 1'b1;
        end
      end

      ABORT: begin
        // Owner keeps stalling until it drops CYC; the other master waits.
        o_grant    = last ? 2'b10 : 2'b01;
        o_timeout  = abort_first;
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;
        if (last) begin
          o_m1_err = abort_first;
        end else begin
          o_m0_err = abort_first;
        end
        if (!owner_cyc) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if ((state_nxt == GRANT0) && (state != GRANT0)) begin
      grant_entry = 1'b1;
      last_nxt    = 1'b0;
    end else if ((state_nxt == GRANT1) && (state != GRANT1)) begin
      grant_entry = 1'b1;
      last_nxt    = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with a short watchdog (TIMEOUT=8).
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err, m0_stall;
  logic [31:0] m0_rdata;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err, m1_stall;
  logic [31:0] m1_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_stall;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_m0_cyc   (m0_cyc),
    .i_m0_stb   (m0_stb),
    .i_m0_we    (m0_we),
    .i_m0_addr  (m0_addr),
    .i_m0_data  (m0_wdata),
    .i_m0_sel   (m0_sel),
    .o_m0_ack   (m0_ack),
    .o_m0_err   (m0_err),
    .o_m0_stall (m0_stall),
    .o_m0_data  (m0_rdata),
    .i_m1_cyc   (m1_cyc),
    .i_m1_stb   (m1_stb),
    .i_m1_we    (m1_we),
    .i_m1_addr  (m1_addr),
    .i_m1_data  (m1_wdata),
    .i_m1_sel   (m1_sel),
    .o_m1_ack   (m1_ack),
    .o_m1_err   (m1_err),
    .o_m1_stall (m1_stall),
    .o_m1_data  (m1_rdata),
    .o_s_cyc    (s_cyc),
    .o_s_stb    (s_stb),
    .o_s_we     (s_we),
    .o_s_addr   (s_addr),
    .o_s_data   (s_wdata),
    .o_s_sel    (s_sel),
    .i_s_ack    (s_ack),
    .i_s_err    (s_err),
    .i_s_stall  (s_stall),
    .i_s_data   (s_rdata),
    .o_grant    (grant),
    .o_timeout  (timeout)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_sel = '0;
    s_ack = 0; s_err = 0; s_stall = 0; s_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    check_val("rst_grant", 64'(grant), 64'h0);
    check_val("rst_timeout", 64'(timeout), 64'h0);
    check_val("rst_s_cyc", 64'(s_cyc), 64'h0);
    check_val("rst_m0_ack", 64'(m0_ack), 64'h0);
    step();
    step();
    rst = 1'b0;

    // 1: single m0 write
    step();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hA5; m0_sel = 4'hF;
    #1;
    check_val("t1_idle_grant", 64'(grant), 64'h0);
    check_val("t1_idle_stall", 64'(m0_stall), 64'h1);
    step();
    #1;
    check_val("t1_grant", 64'(grant), 64'h1);
    check_val("t1_s_cyc", 64'(s_cyc), 64'h1);
    check_val("t1_s_addr", 64'(s_addr), 64'h10);
    check_val("t1_s_data", 64'(s_wdata), 64'hA5);
    check_val("t1_s_we", 64'(s_we), 64'h1);
    s_ack = 1; s_rdata = 32'h1234;
    #1;
    check_val("t1_m0_ack", 64'(m0_ack), 64'h1);
    check_val("t1_m1_ack", 64'(m1_ack), 64'h0);
    check_val("t1_m0_data", 64'(m0_rdata), 64'h1234);
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    check_val("t1_drop_s_cyc", 64'(s_cyc), 64'h0);
    step();
    #1;
    check_val("t1_idle_after", 64'(grant), 64'h0);

    // 2: simultaneous requests right after reset, then direct hand-over
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h20;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h30;
    step();
    #1;
    check_val("t2_grant_m0", 64'(grant), 64'h1);
    check_val("t2_s_addr", 64'(s_addr), 64'h20);
    check_val("t2_m1_stall", 64'(m1_stall), 64'h1);
    s_ack = 1;
    #1;
    check_val("t2_m0_ack", 64'(m0_ack), 64'h1);
    check_val("t2_m1_ack", 64'(m1_ack), 64'h0);
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    check_val("t2_still_m0", 64'(grant), 64'h1);
    step();
    #1;
    check_val("t2_grant_m1", 64'(grant), 64'h2);
    check_val("t2_s_addr_m1", 64'(s_addr), 64'h30);
    s_ack = 1;
    #1;
    check_val("t2_m1_ack", 64'(m1_ack), 64'h1);
    step();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    step();
    #1;
    check_val("t2_idle", 64'(grant), 64'h0);

    // 3: m1 pipelined burst while m0 waits
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h40;
    step();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h99;
    #1;
    check_val("t3_grant_m1", 64'(grant), 64'h2);
    check_val("t3_addr_a", 64'(s_addr), 64'h40);
    check_val("t3_m0_stall_a", 64'(m0_stall), 64'h1);
    step();
    m1_addr = 32'h44; s_stall = 1; s_ack = 1;
    #1;
    check_val("t3_m1_stall", 64'(m1_stall), 64'h1);
    check_val("t3_addr_b", 64'(s_addr), 64'h44);
    check_val("t3_m0_ack_b", 64'(m0_ack), 64'h0);
    step();
    s_stall = 0; s_ack = 0;
    #1;
    check_val("t3_addr_b2", 64'(s_addr), 64'h44);
    step();
    m1_addr = 32'h48; s_ack = 1;
    #1;
    check_val("t3_addr_c", 64'(s_addr), 64'h48);
    check_val("t3_m0_stall_c", 64'(m0_stall), 64'h1);
    step();
    m1_stb = 0;
    #1;
    check_val("t3_m1_ack_d", 64'(m1_ack), 64'h1);
    check_val("t3_m0_ack_d", 64'(m0_ack), 64'h0);
    step();
    m1_cyc = 0;
    #1;
    check_val("t3_ack_on_drop", 64'(m1_ack), 64'h1);
    check_val("t3_m0_ack_e", 64'(m0_ack), 64'h0);
    check_val("t3_m0_stall_e", 64'(m0_stall), 64'h1);
    step();
    s_ack = 0;
    #1;
    check_val("t3_grant_m0", 64'(grant), 64'h1);
    check_val("t3_addr_m0", 64'(s_addr), 64'h99);
    s_ack = 1;
    #1;
    check_val("t3_m0_ack", 64'(m0_ack), 64'h1);
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    step();

    // 4: watchdog abort on m0
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h50;
    step();
    #1;
    check_val("t4_grant", 64'(grant), 64'h1);
    check_val("t4_s_cyc_1", 64'(s_cyc), 64'h1);
    repeat (6) step();
    step();
    #1;
    check_val("t4_s_cyc_8", 64'(s_cyc), 64'h1);
    check_val("t4_no_to_8", 64'(timeout), 64'h0);
    check_val("t4_no_err_8", 64'(m0_err), 64'h0);
    step();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h70;
    #1;
    check_val("t4_ab_s_cyc", 64'(s_cyc), 64'h0);
    check_val("t4_ab_s_stb", 64'(s_stb), 64'h0);
    check_val("t4_ab_err", 64'(m0_err), 64'h1);
    check_val("t4_ab_to", 64'(timeout), 64'h1);
    check_val("t4_ab_grant", 64'(grant), 64'h1);
    check_val("t4_ab_m1_stall", 64'(m1_stall), 64'h1);
    check_val("t4_ab_m1_ack", 64'(m1_ack), 64'h0);
    step();
    #1;
    check_val("t4_ab2_err", 64'(m0_err), 64'h0);
    check_val("t4_ab2_to", 64'(timeout), 64'h0);
    check_val("t4_ab2_stall", 64'(m0_stall), 64'h1);
    check_val("t4_ab2_grant", 64'(grant), 64'h1);
    step();
    #1;
    check_val("t4_ab3_stall", 64'(m0_stall), 64'h1);
    check_val("t4_ab3_ack", 64'(m0_ack), 64'h0);
    step();
    m0_cyc = 0; m0_stb = 0;
    #1;
    check_val("t4_ab4_grant", 64'(grant), 64'h1);
    step();
    #1;
    check_val("t4_idle", 64'(grant), 64'h0);
    check_val("t4_idle_m1_stall", 64'(m1_stall), 64'h1);
    step();
    #1;
    check_val("t4_grant_m1", 64'(grant), 64'h2);
    check_val("t4_addr_m1", 64'(s_addr), 64'h70);
    s_ack = 1;
    #1;
    check_val("t4_m1_ack", 64'(m1_ack), 64'h1);
    step();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    step();

    // 5: acks just before and exactly at the limit keep the transfer alive
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h60; m0_we = 0;
    step();
    #1;
    check_val("t5_grant", 64'(grant), 64'h1);
    step();
    m0_stb = 0;
    repeat (4) step();
    step();
    s_ack = 1;
    #1;
    check_val("t5_ack7", 64'(m0_ack), 64'h1);
    check_val("t5_err7", 64'(m0_err), 64'h0);
    step();
    s_ack = 0; m0_stb = 1;
    #1;
    check_val("t5_stb2", 64'(s_stb), 64'h1);
    step();
    m0_stb = 0;
    #1;
    check_val("t5_c9_s_cyc", 64'(s_cyc), 64'h1);
    check_val("t5_c9_grant", 64'(grant), 64'h1);
    repeat (4) step();
    step();
    s_ack = 1;
    #1;
    check_val("t5_ack14", 64'(m0_ack), 64'h1);
    step();
    s_ack = 0;
    #1;
    check_val("t5_c15_to", 64'(timeout), 64'h0);
    check_val("t5_c15_s_cyc", 64'(s_cyc), 64'h1);
    repeat (7) step();
    s_ack = 1;
    #1;
    check_val("t5_ack_lim", 64'(m0_ack), 64'h1);
    check_val("t5_err_lim", 64'(m0_err), 64'h0);
    check_val("t5_to_lim", 64'(timeout), 64'h0);
    step();
    s_ack = 0;
    #1;
    check_val("t5_after_grant", 64'(grant), 64'h1);
    check_val("t5_after_s_cyc", 64'(s_cyc), 64'h1);
    check_val("t5_after_to", 64'(timeout), 64'h0);
    m0_cyc = 0;
    step();
    step();

    // 6: asynchronous reset mid-transfer
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h80;
    step();
    s_ack = 1;
    #1;
    check_val("t6_s_cyc", 64'(s_cyc), 64'h1);
    check_val("t6_m1_ack", 64'(m1_ack), 64'h1);
    rst = 1'b1;
    #1;
    check_val("t6_rst_s_cyc", 64'(s_cyc), 64'h0);
    check_val("t6_rst_grant", 64'(grant), 64'h0);
    check_val("t6_rst_m1_ack", 64'(m1_ack), 64'h0);
    check_val("t6_rst_m0_ack", 64'(m0_ack), 64'h0);
    rst = 1'b0; s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h90;
    step();
    #1;
    check_val("t6_grant_m0", 64'(grant), 64'h1);
    check_val("t6_addr_m0", 64'(s_addr), 64'h90);
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
